// File: rtl/divn_meter.sv
// rtl/divn_meter.sv - recovers the divide ratio, high time, lock and loss of a slow sampled clock
module divn_meter #(
    parameter int WIDTH    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 255
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             i_clk_div,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_high,
    output logic             o_valid,
    output logic             o_lock,
    output logic             o_lost
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARM   = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;

    localparam int              MW        = $clog2(LOCK_CNT + 1);
    localparam logic [MW-1:0]   MATCH_MAX = MW'(LOCK_CNT);
    localparam logic [MW-1:0]   MATCH_PRE = MW'(LOCK_CNT - 1);
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] TO_VAL   = WIDTH'(TIMEOUT);

    logic             s1, s2, s3;
    logic             rise, fall, timeout, same_meas;
    logic [WIDTH-1:0] per_cnt, hi_cnt, hi_meas;
    logic [MW-1:0]    match_cnt;
    logic [1:0]       state;

    // edge detect on the synchronised input; s3 only serves as the previous sample
    always_comb begin
        rise      = s2 & ~s3;
        fall      = ~s2 & s3;
        timeout   = (state != ST_IDLE) && (per_cnt == TO_VAL) && !rise;
        same_meas = (per_cnt == o_period) && (hi_meas == o_high);
    end

    // three-flop synchroniser for the asynchronous measured clock
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= i_clk_div;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // period and high-time counters, both restarting at 1 on every rising edge
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
            hi_meas <= '0;
        end else begin
            if (rise) begin
                per_cnt <= WIDTH'(1);
                hi_cnt  <= WIDTH'(1);
            end else begin
                if (per_cnt != CNT_MAX)
                    per_cnt <= per_cnt + WIDTH'(1);
                if (s2 && hi_cnt != CNT_MAX)
                    hi_cnt <= hi_cnt + WIDTH'(1);
            end
            if (fall)
                hi_meas <= hi_cnt;
        end
    end

    // measurement FSM: first edge arms, later edges publish, stalled edges declare loss
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            o_period  <= '0;
            o_high    <= '0;
            o_valid   <= 1'b0;
            o_lock    <= 1'b0;
            o_lost    <= 1'b0;
            match_cnt <= '0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise)
                        state <= ST_ARM;
                end
                ST_ARM, ST_TRACK: begin
                    if (rise) begin
                        state    <= ST_TRACK;
                        o_period <= per_cnt;
                        o_high   <= hi_meas;
                        o_valid  <= 1'b1;
                        o_lost   <= 1'b0;
                        if (state == ST_TRACK && same_meas) begin
                            if (match_cnt < MATCH_MAX)
                                match_cnt <= match_cnt + MW'(1);
                            if (match_cnt >= MATCH_PRE)
                                o_lock <= 1'b1;
                        end else begin
                            match_cnt <= MW'(1);
                            o_lock    <= 1'b0;
                        end
                    end else if (timeout) begin
                        state     <= ST_IDLE;
                        o_lost    <= 1'b1;
                        o_lock    <= 1'b0;
                        match_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divn_meter.sv
// tb/tb_divn_meter.sv - directed self-checking bench for divn_meter
module tb_divn_meter;

    logic       sclk = 1'b0;
    logic       rst_n;
    logic       clk_a, clk_b;
    logic [7:0] pa, ha;
    logic [3:0] pb, hb;
    logic       va, lka, lsa, vb, lkb, lsb;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] p;
        logic [7:0] h;
        logic       lk;
        logic       ls;
    } meas_t;

    meas_t qa[$];
    meas_t qb[$];

    always #5 sclk = ~sclk;

    divn_meter #(.WIDTH(8), .LOCK_CNT(4), .TIMEOUT(255)) u_a (
        .sclk(sclk), .rst_n(rst_n), .i_clk_div(clk_a),
        .o_period(pa), .o_high(ha), .o_valid(va), .o_lock(lka), .o_lost(lsa)
    );

    divn_meter #(.WIDTH(4), .LOCK_CNT(4), .TIMEOUT(15)) u_b (
        .sclk(sclk), .rst_n(rst_n), .i_clk_div(clk_b),
        .o_period(pb), .o_high(hb), .o_valid(vb), .o_lock(lkb), .o_lost(lsb)
    );

    always @(negedge sclk) begin
        if (va) qa.push_back('{pa, ha, lka, lsa});
        if (vb) qb.push_back('{{4'b0, pb}, {4'b0, hb}, lkb, lsb});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    task automatic drv(input int sel, input logic v);
        if (sel == 0) clk_a = v;
        else          clk_b = v;
    endtask

    task automatic wave(input int sel, input int hi, input int lo, input int n);
        for (int k = 0; k < n; k++) begin
            drv(sel, 1'b1);
            repeat (hi) @(negedge sclk);
            drv(sel, 1'b0);
            repeat (lo) @(negedge sclk);
        end
    endtask

    task automatic do_reset();
        @(negedge sclk);
        rst_n = 1'b0;
        @(negedge sclk);
        rst_n = 1'b1;
        qa.delete();
        qb.delete();
    endtask

    task automatic check_q(input int sel, input string tag, input int exp_n, input int first,
                           input int p, input int h, input int lock_from);
        int    n;
        meas_t e;
        n = (sel == 0) ? qa.size() : qb.size();
        chk({tag, "_count"}, n, exp_n);
        for (int i = first; i < n && i < exp_n; i++) begin
            if (sel == 0) e = qa[i];
            else          e = qb[i];
            chk($sformatf("%s_period%0d", tag, i), e.p, p);
            chk($sformatf("%s_high%0d", tag, i), e.h, h);
            chk($sformatf("%s_lock%0d", tag, i), e.lk, (i >= lock_from));
            chk($sformatf("%s_lost%0d", tag, i), e.ls, 0);
        end
    endtask

    initial begin
        meas_t e;
        int    waited;
        rst_n = 1'b0;
        clk_a = 1'b0;
        clk_b = 1'b0;
        repeat (3) @(negedge sclk);
        chk("rst_period", pa, 0);
        chk("rst_high", ha, 0);
        chk("rst_valid", va, 0);
        chk("rst_lock", lka, 0);
        chk("rst_lost", lsa, 0);
        rst_n = 1'b1;
        @(negedge sclk);

        // square wave N=4
        qa.delete();
        wave(0, 2, 2, 6);
        repeat (4) @(negedge sclk);
        check_q(0, "t1", 5, 0, 4, 2, 3);

        // odd N=5, high 2
        do_reset();
        wave(0, 2, 3, 6);
        repeat (4) @(negedge sclk);
        check_q(0, "t2", 5, 0, 5, 2, 3);

        // lock at N=4 then switch to N=6
        do_reset();
        wave(0, 2, 2, 5);
        chk("t3_lock4", lka, 1);
        qa.delete();
        wave(0, 3, 3, 5);
        repeat (4) @(negedge sclk);
        if (qa.size() > 0) begin
            e = qa[0];
            chk("t3_tail_period", e.p, 4);
            chk("t3_tail_lock", e.lk, 1);
        end
        check_q(0, "t3", 5, 1, 6, 3, 4);

        // loss after input stops, then recovery
        do_reset();
        wave(0, 2, 2, 5);
        repeat (4) @(negedge sclk);
        qa.delete();
        repeat (200) @(negedge sclk);
        chk("t4_early_lost", lsa, 0);
        waited = 0;
        while (!lsa && waited < 100) begin
            @(negedge sclk);
            waited++;
        end
        chk("t4_lost", lsa, 1);
        chk("t4_lock", lka, 0);
        chk("t4_period_hold", pa, 4);
        chk("t4_high_hold", ha, 2);
        chk("t4_no_valid", qa.size(), 0);
        wave(0, 2, 2, 3);
        repeat (4) @(negedge sclk);
        check_q(0, "t4r", 2, 0, 4, 2, 99);

        // reset pulse while locked
        do_reset();
        wave(0, 2, 2, 5);
        chk("t5_lock_pre", lka, 1);
        rst_n = 1'b0;
        @(negedge sclk);
        chk("t5_period", pa, 0);
        chk("t5_high", ha, 0);
        chk("t5_lock", lka, 0);
        chk("t5_lost", lsa, 0);
        chk("t5_valid", va, 0);
        rst_n = 1'b1;
        qa.delete();
        wave(0, 2, 2, 3);
        repeat (4) @(negedge sclk);
        check_q(0, "t5", 2, 0, 4, 2, 99);

        // minimum period of 2
        do_reset();
        wave(0, 1, 1, 4);
        repeat (4) @(negedge sclk);
        check_q(0, "t7", 3, 0, 2, 1, 99);

        // narrow instance: period 14 measured, period 16 lost
        do_reset();
        wave(1, 7, 7, 4);
        wave(1, 8, 8, 4);
        repeat (4) @(negedge sclk);
        check_q(1, "t6", 4, 0, 14, 7, 3);
        chk("t6_lost", lsb, 1);
        chk("t6_period_hold", pb, 14);
        chk("t6_lock", lkb, 0);

        // narrow instance: period 15, rise coincides with timeout
        do_reset();
        wave(1, 8, 7, 4);
        check_q(1, "t8", 3, 0, 15, 8, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
